conv_inst_sequencer: RTL

- Control FSM that generates the 34-bit `inst` word consumed by `core`, directly upstream of it.
- Runs one full weight-stationary convolution pass, repeating these phases for each kernel position kij:
  - weight SRAM → L0
  - L0 → PE kernel load
  - activation SRAM → L0
  - execute
  - OFIFO drain → psum SRAM
- Replaces hand-written testbench instruction streams, so a convolution is started by a single `start` pulse.

---
 rtl/conv_inst_sequencer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/conv_inst_sequencer.sv
// conv_inst_sequencer: drives the 34-bit core instruction word through one
// full weight-stationary convolution pass. The pass runs over KIJ kernel
// positions and is launched by a single start pulse.
// Every output is a flop loaded from the decode of the current FSM state.
// The externally visible word therefore trails the internal state by one
// cycle. This keeps inst glitch-free and lets the DRAIN write strobe
// follow the sampled ofifo_valid.
// Optional build macro SEQ_PERF_EN adds perf_cycles, a count of busy cycles.
// The inst field packing assumes ADDR_W = 11.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; idle word on inst
// W_RD     | ROW weight reads from xmem, l0_wr trails the read by one cycle
// W_FLUSH  | last weight write into L0
// W_LOAD   | LOAD_CYC cycles of load + l0_rd into the PE array
// X_RD     | NIJ activation reads from xmem, l0_wr trails by one cycle
// X_FLUSH  | last activation write into L0
// EXEC     | NIJ cycles of execute + l0_rd
// DRAIN    | one psum write to pmem per ofifo_valid, NIJ writes total
// DONE     | one-cycle completion, then back to IDLE
module conv_inst_sequencer #(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int NIJ      = 36,
  parameter int KIJ      = 9,
  parameter int LOAD_CYC = ROW + COL,
  parameter int ADDR_W   = 11,
  parameter int W_BASE   = 0,
  parameter int X_BASE   = 1024,
  parameter int P_BASE   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done
`ifdef SEQ_PERF_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  localparam int CNT_MAX = (ROW > LOAD_CYC) ? ((ROW > NIJ) ? ROW : NIJ)
                                            : ((LOAD_CYC > NIJ) ? LOAD_CYC : NIJ);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int KIJ_W = $clog2(KIJ + 1);

  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(ROW - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYC - 1);
  localparam logic [CNT_W-1:0] NIJ_LAST  = CNT_W'(NIJ - 1);
  localparam logic [KIJ_W-1:0] KIJ_LAST  = KIJ_W'(KIJ - 1);

  // CEN/WEN of both SRAMs high, everything else low.
  localparam logic [33:0] IDLE_WORD = (34'd1 << 32) | (34'd1 << 31) |
                                      (34'd1 << 19) | (34'd1 << 18);

  typedef enum logic [3:0] {
    S_IDLE, S_W_RD, S_W_FLUSH, S_W_LOAD, S_X_RD, S_X_FLUSH, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [KIJ_W-1:0]    r_kij, w_kij_nxt;
  logic [33:0]         r_inst, w_inst_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                w_start_ok;

  logic                w_cen_p, w_wen_p, w_cen_x;
  logic [ADDR_W-1:0]   w_a_p, w_a_x;
  logic                w_ofifo_rd, w_l0_rd, w_l0_wr, w_exec, w_load;

  // The done cycle still counts as the tail of the pass, so start is
  // only taken from a quiet IDLE.
  assign w_start_ok = start && (r_state == S_IDLE) && !r_done;

  // State, counters and all output flops; reset aborts to the idle word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_kij   <= '0;
      r_inst  <= IDLE_WORD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_kij   <= w_kij_nxt;
      r_inst  <= w_inst_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state transitions and decode of the instruction fields for the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_kij_nxt   = r_kij;
    w_busy_nxt  = 1'b1;
    w_done_nxt  = 1'b0;
    w_cen_p     = 1'b1;
    w_wen_p     = 1'b1;
    w_a_p       = '0;
    w_cen_x     = 1'b1;
    w_a_x       = '0;
    w_ofifo_rd  = 1'b0;
    w_l0_rd     = 1'b0;
    w_l0_wr     = 1'b0;
    w_exec      = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (w_start_ok) begin
          w_state_nxt = S_W_RD;
          w_cnt_nxt   = '0;
          w_kij_nxt   = '0;
        end
      end
      S_W_RD: begin
        w_cen_x = 1'b0;
        w_a_x   = ADDR_W'(W_BASE) + ADDR_W'(r_kij) * ADDR_W'(ROW) + ADDR_W'(r_cnt);
        w_l0_wr = (r_cnt != '0);
        if (r_cnt == ROW_LAST) begin
          w_state_nxt = S_W_FLUSH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_W_FLUSH: begin
        w_l0_wr     = 1'b1;
        w_state_nxt = S_W_LOAD;
        w_cnt_nxt   = '0;
      end
      S_W_LOAD: begin
        w_load  = 1'b1;
        w_l0_rd = 1'b1;
        if (r_cnt == LOAD_LAST) begin
          w_state_nxt = S_X_RD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_X_RD: begin
        w_cen_x = 1'b0;
        w_a_x   = ADDR_W'(X_BASE) + ADDR_W'(r_cnt);
        w_l0_wr = (r_cnt != '0);
        if (r_cnt == NIJ_LAST) begin
          w_state_nxt = S_X_FLUSH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_X_FLUSH: begin
        w_l0_wr     = 1'b1;
        w_state_nxt = S_EXEC;
        w_cnt_nxt   = '0;
      end
      S_EXEC: begin
        w_exec  = 1'b1;
        w_l0_rd = 1'b1;
        if (r_cnt == NIJ_LAST) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // r_cnt is the psum write index within this kernel position.
        if (ofifo_valid) begin
          w_ofifo_rd = 1'b1;
          w_cen_p    = 1'b0;
          w_wen_p    = 1'b0;
          w_a_p      = ADDR_W'(P_BASE) + ADDR_W'(r_kij) * ADDR_W'(NIJ) + ADDR_W'(r_cnt);
          if (r_cnt == NIJ_LAST) begin
            w_cnt_nxt = '0;
            if (r_kij == KIJ_LAST) begin
              w_state_nxt = S_DONE;
            end else begin
              w_kij_nxt   = r_kij + KIJ_W'(1);
              w_state_nxt = S_W_RD;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // acc, ififo_wr, ififo_rd are never used; xmem is read-only.
    w_inst_nxt = {1'b0, w_cen_p, w_wen_p, w_a_p, w_cen_x, 1'b1, w_a_x,
                  w_ofifo_rd, 1'b0, 1'b0, w_l0_rd, w_l0_wr, w_exec, w_load};
  end

  assign inst = r_inst;
  assign busy = r_busy;
  assign done = r_done;

`ifdef SEQ_PERF_EN
  logic [31:0] r_perf;

  // Busy-cycle counter: cleared by an accepted start, frozen once the pass ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf <= '0;
    end else if (w_start_ok) begin
      r_perf <= '0;
    end else if (r_busy) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif

endmodule
